// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MIPS multiply/divide unit owning HI/LO.
// Optional divider datapath enabled by defining MULDIV_DIV_EN.
module muldiv_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] busA,
   input  logic [31:0] busB,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_SIGN = 2'd2
   } state_t;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MULDIV_DIV_EN
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
`endif

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] b_q, b_d;
   logic [63:0] acc_q, acc_d;
   logic        neg_q, neg_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        mul_req;
   logic        div_req;
   logic        idle;
   logic        go;
   logic        sgn_op;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   logic [63:0] prod;

`ifdef MULDIV_DIV_EN
   logic        is_div_q, is_div_d;
   logic        neg_rem_q, neg_rem_d;
   logic [31:0] orig_a_q, orig_a_d;
   logic        dz_q, dz_d;
   logic [32:0] div_shift;
   logic [32:0] div_diff;
   logic [63:0] div_next;
   assign div_req = (op == OP_DIV) || (op == OP_DIVU);
`else
   assign div_req = 1'b0;
`endif

   assign mul_req = (op == OP_MULT) || (op == OP_MULTU);
   assign idle    = (state_q == S_IDLE);
   assign go      = idle && start && (mul_req || div_req);
   // MULT and DIV both have op[0] clear
   assign sgn_op  = ~op[0];
   assign abs_a   = (sgn_op && busA[31]) ? (32'd0 - busA) : busA;
   assign abs_b   = (sgn_op && busB[31]) ? (32'd0 - busB) : busB;

   // Shift-add step: conditional add into the upper half, then shift right
   always_comb begin
      mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
      mul_next = {mul_sum, acc_q[31:1]};
      prod     = neg_q ? (64'd0 - acc_q) : acc_q;
   end

`ifdef MULDIV_DIV_EN
   // Restoring step: shift in next dividend bit, keep difference if no borrow
   always_comb begin
      div_shift = {acc_q[63:32], acc_q[31]};
      div_diff  = div_shift - {1'b0, b_q};
      if (div_diff[32])
         div_next = {div_shift[31:0], acc_q[30:0], 1'b0};
      else
         div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
   end
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (go) state_d = S_CALC;
         S_CALC:  if (cnt_q == 5'd31) state_d = S_SIGN;
         S_SIGN:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and output next values per state
   always_comb begin
      cnt_d  = cnt_q;
      b_d    = b_q;
      acc_d  = acc_q;
      neg_d  = neg_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      busy_d = busy_q;
      done_d = 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_d  = is_div_q;
      neg_rem_d = neg_rem_q;
      orig_a_d  = orig_a_q;
      dz_d      = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (go) begin
               // Multiplier or dividend goes in the low half, B held aside
               b_d    = abs_b;
               acc_d  = {32'd0, abs_a};
               cnt_d  = 5'd0;
               neg_d  = sgn_op && (busA[31] ^ busB[31]);
               busy_d = 1'b1;
`ifdef MULDIV_DIV_EN
               is_div_d  = div_req;
               neg_rem_d = sgn_op && busA[31];
               orig_a_d  = busA;
`endif
            end else if (start && op == OP_MTHI) begin
               hi_d = busA;
            end else if (start && op == OP_MTLO) begin
               lo_d = busA;
            end
         end
         S_CALC: begin
            cnt_d = cnt_q + 5'd1;
`ifdef MULDIV_DIV_EN
            acc_d = is_div_q ? div_next : mul_next;
`else
            acc_d = mul_next;
`endif
         end
         S_SIGN: begin
            busy_d = 1'b0;
            done_d = 1'b1;
            {hi_d, lo_d} = prod;
`ifdef MULDIV_DIV_EN
            if (is_div_q) begin
               if (b_q == 32'd0) begin
                  hi_d = orig_a_q;
                  lo_d = 32'hFFFF_FFFF;
                  dz_d = 1'b1;
               end else begin
                  lo_d = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
                  hi_d = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
               end
            end
`endif
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= 5'd0;
         b_q    <= 32'd0;
         acc_q  <= 64'd0;
         neg_q  <= 1'b0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef MULDIV_DIV_EN
         is_div_q  <= 1'b0;
         neg_rem_q <= 1'b0;
         orig_a_q  <= 32'd0;
         dz_q      <= 1'b0;
`endif
      end else begin
         cnt_q  <= cnt_d;
         b_q    <= b_d;
         acc_q  <= acc_d;
         neg_q  <= neg_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         busy_q <= busy_d;
         done_q <= done_d;
`ifdef MULDIV_DIV_EN
         is_div_q  <= is_div_d;
         neg_rem_q <= neg_rem_d;
         orig_a_q  <= orig_a_d;
         dz_q      <= dz_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
`ifdef MULDIV_DIV_EN
   assign div_by_zero = dz_q;
`else
   assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Divide tests follow MULDIV_DIV_EN.
module tb_muldiv_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] busA;
   logic [31:0] busB;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int errors;
   int checks;

   muldiv_unit dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .op(op),
      .busA(busA),
      .busB(busB),
      .busy(busy),
      .done(done),
      .div_by_zero(div_by_zero),
      .hi(hi),
      .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one op from just after an edge; return at the done cycle
   task automatic do_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int nbusy,
                        output logic early);
      start = 1'b1;
      op    = o;
      busA  = a;
      busB  = b;
      @(posedge clk); #1;
      start = 1'b0;
      nbusy = busy ? 1 : 0;
      early = done;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (!busy) break;
         nbusy++;
         if (done) early = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      op    = 3'd0;
      busA  = 32'd0;
      busB  = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (hi !== 32'd0) begin
         errors++; $display("FAIL reset_hi got=%h exp=0", hi);
      end
      checks++;
      if (lo !== 32'd0) begin
         errors++; $display("FAIL reset_lo got=%h exp=0", lo);
      end
      checks++;
      if ({busy, done, div_by_zero} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got=%b exp=000", {busy, done, div_by_zero});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mult();
      int n;
      logic early;
      do_op(3'b000, 32'hFFFF_FFFE, 32'd3, n, early);
      checks++;
      if (n !== 33) begin
         errors++; $display("FAIL mult_busy_cycles got=%0d exp=33", n);
      end
      checks++;
      if (done !== 1'b1 || early !== 1'b0) begin
         errors++; $display("FAIL mult_done got=%b early=%b exp=1/0", done, early);
      end
      checks++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
         errors++; $display("FAIL mult_neg got=%h_%h exp=ffffffff_fffffffa", hi, lo);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL mult_done_pulse got=%b exp=0", done);
      end
      do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, early);
      checks++;
      if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
         errors++; $display("FAIL multu_max got=%h_%h exp=fffffffe_00000001", hi, lo);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      logic early;
      do_op(3'b000, 32'd4, 32'd4, n, early);
      checks++;
      if ({hi, lo} !== 64'd16) begin
         errors++; $display("FAIL b2b_first got=%h_%h exp=0_10", hi, lo);
      end
      // Issued from the done cycle, sampled on the following edge
      do_op(3'b001, 32'h0001_0000, 32'h0001_0000, n, early);
      checks++;
      if (n !== 33) begin
         errors++; $display("FAIL b2b_busy_cycles got=%0d exp=33", n);
      end
      checks++;
      if ({hi, lo} !== 64'h0000_0001_0000_0000) begin
         errors++; $display("FAIL b2b_second got=%h_%h exp=1_0", hi, lo);
      end
      @(posedge clk); #1;
   endtask

`ifdef MULDIV_DIV_EN
   task automatic test_div();
      int n;
      logic early;
      do_op(3'b010, 32'hFFFF_FFF9, 32'd2, n, early);
      checks++;
      if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL div_neg7_2 got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", hi, lo);
      end
      checks++;
      if (div_by_zero !== 1'b0 || done !== 1'b1) begin
         errors++; $display("FAIL div_flags got dz=%b done=%b exp 0/1", div_by_zero, done);
      end
      @(posedge clk); #1;
      do_op(3'b010, 32'd7, 32'hFFFF_FFFE, n, early);
      checks++;
      if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin
         errors++; $display("FAIL div_7_neg2 got hi=%h lo=%h exp hi=1 lo=fffffffd", hi, lo);
      end
      @(posedge clk); #1;
      do_op(3'b011, 32'd100, 32'd0, n, early);
      checks++;
      if (n !== 33) begin
         errors++; $display("FAIL divz_busy_cycles got=%0d exp=33", n);
      end
      checks++;
      if (hi !== 32'd100 || lo !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL divz_result got hi=%h lo=%h exp hi=64 lo=ffffffff", hi, lo);
      end
      checks++;
      if (div_by_zero !== 1'b1 || done !== 1'b1) begin
         errors++; $display("FAIL divz_flags got dz=%b done=%b exp 1/1", div_by_zero, done);
      end
      @(posedge clk); #1;
      checks++;
      if (div_by_zero !== 1'b0) begin
         errors++; $display("FAIL divz_pulse got=%b exp=0", div_by_zero);
      end
      do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, n, early);
      checks++;
      if (lo !== 32'h8000_0000 || hi !== 32'd0 || div_by_zero !== 1'b0) begin
         errors++; $display("FAIL div_ovf got hi=%h lo=%h dz=%b exp hi=0 lo=80000000 dz=0", hi, lo, div_by_zero);
      end
      do_op(3'b011, 32'd1000, 32'd7, n, early);
      checks++;
      if (lo !== 32'd142 || hi !== 32'd6) begin
         errors++; $display("FAIL divu_1000_7 got hi=%h lo=%h exp hi=6 lo=8e", hi, lo);
      end
      @(posedge clk); #1;
   endtask
`else
   task automatic test_div_disabled();
      logic seen;
      seen = 1'b0;
      start = 1'b1;
      op    = 3'b010;
      busA  = 32'd10;
      busB  = 32'd2;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (busy || done) seen = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL nodiv_activity got=%b exp=0", seen);
      end
      checks++;
      if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
         errors++; $display("FAIL nodiv_hold got hi=%h lo=%h exp hi=12345678 lo=9abcdef0", hi, lo);
      end
   endtask
`endif

   task automatic test_mthi_mtlo();
      start = 1'b1;
      op    = 3'b100;
      busA  = 32'h1234_5678;
      @(posedge clk); #1;
      checks++;
      if (hi !== 32'h1234_5678 || busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL mthi got hi=%h busy=%b done=%b exp 12345678/0/0", hi, busy, done);
      end
      op   = 3'b101;
      busA = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678 || busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL mtlo got hi=%h lo=%h busy=%b done=%b exp 12345678/9abcdef0/0/0", hi, lo, busy, done);
      end
      op = 3'b110;
      start = 1'b1;
      busA = 32'hFFFF_0000;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0 || busy !== 1'b0) begin
         errors++; $display("FAIL reserved_op got hi=%h lo=%h busy=%b exp unchanged/0", hi, lo, busy);
      end
   endtask

   task automatic test_busy_ignore_and_abort();
      logic seen;
      int   cyc;
      start = 1'b1;
      op    = 3'b000;
      busA  = 32'd5;
      busB  = 32'd6;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         cyc++;
         start = (cyc == 10);
         op    = 3'b101;
         busA  = 32'hDEAD_BEEF;
         if (done) break;
      end
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || cyc !== 33) begin
         errors++; $display("FAIL ignore_latency got done=%b cyc=%0d exp 1/33", done, cyc);
      end
      checks++;
      if (lo !== 32'd30 || hi !== 32'd0) begin
         errors++; $display("FAIL ignore_mtlo got hi=%h lo=%h exp hi=0 lo=1e", hi, lo);
      end
      @(posedge clk); #1;
      start = 1'b1;
      op    = 3'b000;
      busA  = 32'd7;
      busB  = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL abort got hi=%h lo=%h busy=%b exp 0/0/0", hi, lo, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (busy || done) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0 || lo !== 32'd0) begin
         errors++; $display("FAIL abort_resume got seen=%b lo=%h exp 0/0", seen, lo);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_mult();
      test_back_to_back();
      test_mthi_mtlo();
`ifdef MULDIV_DIV_EN
      test_div();
`else
      test_div_disabled();
`endif
      test_busy_ignore_and_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the 32-bit MIPS datapath. It sits directly downstream of the register file and consumes the two read buses (rs on busA, rt on busB) for MULT/MULTU/DIV/DIVU/MTHI/MTLO. It produces the architectural HI/LO registers that MFHI/MFLO read. While an operation is in flight it raises `busy` so the control/hazard logic can stall.

## Interface
- Parameters: none; datapath width is fixed at 32.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled on a rising edge while idle.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
- `busA`  in  32  rs operand: multiplicand/dividend; MTHI/MTLO source.
- `busB`  in  32  rt operand: multiplier/divisor.
- `busy`  out  1  high while a multiply/divide is in progress.
- `done`  out  1  one-cycle pulse when HI/LO receive a multiply/divide result.
- `div_by_zero`  out  1  one-cycle pulse coincident with `done` when the divisor was 0.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, CALC, SIGN.
- IDLE, `start` with MULT/MULTU/DIV/DIVU:
  - Latch the operands.
  - For signed ops, latch absolute values and record the result signs: product/quotient sign = A[31]^B[31]; remainder sign = A[31].
  - Clear the 5-bit iteration counter and go to CALC.
- IDLE, `start` with MTHI/MTLO: write busA into hi/lo on that edge. No busy, no done, state stays IDLE.
- IDLE, `start` with a reserved op: ignored.
- CALC, multiply: shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
- CALC, divide: restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
- CALC: after 32 iterations (counter wraps 31→0), go to SIGN.
- SIGN:
  - Apply the recorded sign corrections by two's-complement negation.
  - Multiply: {hi,lo} = 64-bit product.
  - Divide: lo = quotient, hi = remainder.
  - Pulse `done` and return to IDLE.
- Divide by zero: hi = original busA, lo = 32'hFFFF_FFFF, and `div_by_zero` pulses with `done`. The full 33-cycle latency is still used.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: lo = 0x8000_0000, hi = 0. No flag.
- `start` while busy (any op, including MTHI/MTLO) is ignored. The operation in flight is unaffected, and upstream must stall on `busy`.
- `hi`/`lo` hold their values at all times except on a result write or an MTHI/MTLO write.

## Timing
- Reset (async, immediate): state IDLE, counter 0, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `div_by_zero` = 0.
- Reset asserted mid-operation aborts it. HI/LO clear to 0 and nothing resumes after reset is released.
- Edge E0 samples `start`. From that edge, `busy` = 1.
- Edges E0+1 … E0+32 perform the 32 iterations. Edge E0+32 enters SIGN.
- Edge E0+33 writes hi/lo, sets `done` = 1 and `busy` = 0. After E0+33 the unit is in IDLE.
- Totals: `busy` high exactly 33 cycles; result visible on `hi`/`lo` in the same cycle `done` is high.
- A new `start` may be sampled at edge E0+33 + 1 (i.e. in the `done` cycle), giving back-to-back operations every 34 cycles.
- MTHI/MTLO: written value visible on `hi`/`lo` immediately after the sampling edge (latency 1).
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `MULDIV_DIV_EN` defined: full behaviour as above.
- `MULDIV_DIV_EN` undefined:
  - Division datapath omitted.
  - DIV/DIVU are treated as reserved ops: ignored, no busy, no done, hi/lo unchanged.
  - `div_by_zero` tied to 0.
  - Multiply and MTHI/MTLO are unchanged.

## Test plan
- Reset then MULT busA = 0xFFFF_FFFE (-2), busB = 3: `busy` high 33 cycles; then hi = 0xFFFF_FFFF, lo = 0xFFFF_FFFA, `done` pulses once.
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF: hi = 0xFFFF_FFFE, lo = 0x0000_0001.
- DIV -7 / 2: lo = 0xFFFF_FFFD (-3), hi = 0xFFFF_FFFF (-1). DIVU 100 / 0: hi = 100, lo = 0xFFFF_FFFF, `div_by_zero` pulses with `done`.
- MTHI 0x1234_5678, then MTLO 0x9ABC_DEF0 on the next cycle: values visible one edge after each; `busy` and `done` stay 0.
- Start MULT 5×6; at cycle 10 issue MTLO 0xDEAD_BEEF: ignored, final lo = 30. Then assert `rst_n` = 0 at cycle 15 of a second MULT: hi = lo = 0, `busy` = 0 immediately, no `done` afterwards.
- Build without `MULDIV_DIV_EN`: DIV 10 / 2 leaves hi/lo unchanged with `busy`/`done` never asserted; MULT 4 × 4 still gives lo = 16.
